// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I lab CPU.
// Sequences FETCH / DECODE / EXEC / MEM / WB over a shared ALU and one
// memory port. All datapath controls are combinational from state and IR.
// Build option: define ILLEGAL_HALT_EN to halt (sticky illegal flag) on an
// unsupported opcode; otherwise it is executed as a NOP with a one-cycle
// illegal pulse.
module multicycle_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic [2:0]  state,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        mem_re,
   output logic        mem_we,
   output logic [2:0]  imm_type,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_op,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
      C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILLEGAL
   } cls_t;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_PASSB = 4'd10;

   state_t     state_q, state_d;
   cls_t       cls;
   logic [3:0] arith_op;

   // raw strobes before reset gating
   logic ir_we_c, pc_we_c, mem_re_c, mem_we_c, rf_we_c;

   // only opcode, funct3 and funct7[5] steer control
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

   // opcode classification
   always_comb begin
      cls = C_ILLEGAL;
      case (inst[6:0])
         7'b0110111: cls = C_LUI;
         7'b0010111: cls = C_AUIPC;
         7'b1101111: cls = C_JAL;
         7'b1100111: cls = C_JALR;
         7'b1100011: cls = C_BRANCH;
         7'b0000011: cls = C_LOAD;
         7'b0100011: cls = C_STORE;
         7'b0010011: cls = C_OPIMM;
         7'b0110011: cls = C_OP;
         default:    cls = C_ILLEGAL;
      endcase
   end

   // funct3 / funct7[5] to ALU op for OP and OPIMM (OPIMM never subtracts)
   always_comb begin
      arith_op = OP_ADD;
      case (inst[14:12])
         3'd0: arith_op = (inst[30] && cls == C_OP) ? OP_SUB : OP_ADD;
         3'd1: arith_op = OP_SLL;
         3'd2: arith_op = OP_SLT;
         3'd3: arith_op = OP_SLTU;
         3'd4: arith_op = OP_XOR;
         3'd5: arith_op = inst[30] ? OP_SRA : OP_SRL;
         3'd6: arith_op = OP_OR;
         3'd7: arith_op = OP_AND;
         default: arith_op = OP_ADD;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= state_t'(RESET_STATE);
      else     state_q <= state_d;
   end

   // next-state and control outputs
   always_comb begin
      state_d   = state_q;
      ir_we_c   = 1'b0;
      pc_we_c   = 1'b0;
      mem_re_c  = 1'b0;
      mem_we_c  = 1'b0;
      rf_we_c   = 1'b0;
      pc_sel    = 2'd0;
      imm_type  = 3'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = OP_ADD;
      wb_sel    = 2'd0;

      if (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB) begin
         case (cls)
            C_OPIMM, C_LOAD, C_JALR: imm_type = 3'd1;
            C_STORE:                 imm_type = 3'd2;
            C_BRANCH:                imm_type = 3'd3;
            C_LUI, C_AUIPC:          imm_type = 3'd4;
            C_JAL:                   imm_type = 3'd5;
            default:                 imm_type = 3'd0;
         endcase
      end

      // ALU selects stay as in EXEC through MEM and WB
      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
         case (cls)
            C_OP:    alu_op = arith_op;
            C_OPIMM: begin alu_b_sel = 1'b1; alu_op = arith_op; end
            C_LUI:   begin alu_b_sel = 1'b1; alu_op = OP_PASSB; end
            C_AUIPC, C_JAL, C_BRANCH: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
            C_JALR, C_LOAD, C_STORE:  alu_b_sel = 1'b1;
            default: ;
         endcase
      end

      case (state_q)
         FETCH: begin
            mem_re_c = 1'b1;
            if (mem_ready) begin
               ir_we_c = 1'b1;
               pc_we_c = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (cls == C_ILLEGAL) begin
`ifdef ILLEGAL_HALT_EN
               state_d = HALT;
`else
               state_d = FETCH;
`endif
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            case (cls)
               C_JAL:    begin pc_we_c = 1'b1; pc_sel = 2'd1; state_d = WB; end
               C_JALR:   begin pc_we_c = 1'b1; pc_sel = 2'd2; state_d = WB; end
               C_BRANCH: begin pc_we_c = br_taken; pc_sel = 2'd1; state_d = FETCH; end
               C_LOAD, C_STORE: state_d = MEM;
               default:  state_d = WB;
            endcase
         end
         MEM: begin
            if (cls == C_STORE) mem_we_c = 1'b1;
            else                mem_re_c = 1'b1;
            if (mem_ready) state_d = (cls == C_STORE) ? FETCH : WB;
         end
         WB: begin
            rf_we_c = 1'b1;
            case (cls)
               C_LOAD:        wb_sel = 2'd1;
               C_JAL, C_JALR: wb_sel = 2'd2;
               default:       wb_sel = 2'd0;
            endcase
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // reset suppresses every strobe immediately, abandoning any access
   assign ir_we  = ir_we_c  & ~rst;
   assign pc_we  = pc_we_c  & ~rst;
   assign mem_re = mem_re_c & ~rst;
   assign mem_we = mem_we_c & ~rst;
   assign rf_we  = rf_we_c  & ~rst;
   assign state  = state_q;

`ifdef ILLEGAL_HALT_EN
   logic illegal_q, illegal_d;

   // sticky illegal flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   assign illegal_d = illegal_q | (state_q == DECODE && cls == C_ILLEGAL);
   assign illegal   = illegal_q;
`else
   assign illegal = (state_q == DECODE) && (cls == C_ILLEGAL) && !rst;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst, mem_ready, br_taken;
   logic [31:0] inst;
   logic [2:0]  state, imm_type;
   logic        ir_we, pc_we, mem_re, mem_we, alu_a_sel, alu_b_sel, rf_we, illegal;
   logic [1:0]  pc_sel, wb_sel;
   logic [3:0]  alu_op;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
      .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
      .state(state), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .mem_re(mem_re), .mem_we(mem_we), .imm_type(imm_type),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
      .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // accept instruction in FETCH; returns in DECODE
   task automatic fetch(input logic [31:0] i);
      inst = i;
      mem_ready = 1'b1;
      #1;
      chk("fetch_state", {29'd0, state}, 32'd0);
      tick;
   endtask

   initial begin
      rst = 1'b1; inst = '0; mem_ready = 1'b0; br_taken = 1'b0;
      tick; tick;
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);

      rst = 1'b0; #1;
      chk("fetch_mem_re", {31'd0, mem_re}, 32'd1);
      chk("fetch_wait_ir_we", {31'd0, ir_we}, 32'd0);
      tick;
      chk("fetch_hold_state", {29'd0, state}, 32'd0);
      chk("fetch_hold_pc_we", {31'd0, pc_we}, 32'd0);

      // add x3,x1,x2
      inst = 32'h002081B3; mem_ready = 1'b1; #1;
      chk("add_f_ir_we", {31'd0, ir_we}, 32'd1);
      chk("add_f_pc_we", {31'd0, pc_we}, 32'd1);
      chk("add_f_pc_sel", {30'd0, pc_sel}, 32'd0);
      tick;
      chk("add_d_state", {29'd0, state}, 32'd1);
      tick;
      chk("add_e_state", {29'd0, state}, 32'd2);
      chk("add_e_alu_op", {28'd0, alu_op}, 32'd0);
      chk("add_e_b_sel", {31'd0, alu_b_sel}, 32'd0);
      chk("add_e_imm", {29'd0, imm_type}, 32'd0);
      tick;
      chk("add_w_state", {29'd0, state}, 32'd4);
      chk("add_w_rf_we", {31'd0, rf_we}, 32'd1);
      chk("add_w_wb_sel", {30'd0, wb_sel}, 32'd0);
      tick;
      chk("add_end_state", {29'd0, state}, 32'd0);
      chk("add_end_rf_we", {31'd0, rf_we}, 32'd0);

      // lw x5,8(x1) with 3 wait cycles in MEM
      fetch(32'h0080A283);
      chk("lw_d_imm", {29'd0, imm_type}, 32'd1);
      tick;
      chk("lw_e_state", {29'd0, state}, 32'd2);
      chk("lw_e_b_sel", {31'd0, alu_b_sel}, 32'd1);
      chk("lw_e_mem_re", {31'd0, mem_re}, 32'd0);
      mem_ready = 1'b0;
      tick;
      for (int k = 0; k < 3; k++) begin
         chk("lw_m_wait_state", {29'd0, state}, 32'd3);
         chk("lw_m_wait_mem_re", {31'd0, mem_re}, 32'd1);
         tick;
      end
      mem_ready = 1'b1; #1;
      chk("lw_m_last_state", {29'd0, state}, 32'd3);
      chk("lw_m_last_mem_re", {31'd0, mem_re}, 32'd1);
      chk("lw_m_b_sel", {31'd0, alu_b_sel}, 32'd1);
      tick;
      chk("lw_w_state", {29'd0, state}, 32'd4);
      chk("lw_w_rf_we", {31'd0, rf_we}, 32'd1);
      chk("lw_w_wb_sel", {30'd0, wb_sel}, 32'd1);
      chk("lw_w_mem_re", {31'd0, mem_re}, 32'd0);
      tick;
      chk("lw_end_state", {29'd0, state}, 32'd0);

      // beq taken
      fetch(32'h00000863);
      br_taken = 1'b1;
      tick;
      chk("beqt_e_pc_we", {31'd0, pc_we}, 32'd1);
      chk("beqt_e_pc_sel", {30'd0, pc_sel}, 32'd1);
      chk("beqt_e_imm", {29'd0, imm_type}, 32'd3);
      chk("beqt_e_a_sel", {31'd0, alu_a_sel}, 32'd1);
      tick;
      chk("beqt_end_state", {29'd0, state}, 32'd0);

      // beq not taken
      fetch(32'h00000863);
      br_taken = 1'b0;
      tick;
      chk("beqn_e_pc_we", {31'd0, pc_we}, 32'd0);
      tick;
      chk("beqn_end_state", {29'd0, state}, 32'd0);

      // jalr x1,0(x2)
      fetch(32'h000100E7);
      tick;
      chk("jalr_e_pc_we", {31'd0, pc_we}, 32'd1);
      chk("jalr_e_pc_sel", {30'd0, pc_sel}, 32'd2);
      chk("jalr_e_a_sel", {31'd0, alu_a_sel}, 32'd0);
      tick;
      chk("jalr_w_rf_we", {31'd0, rf_we}, 32'd1);
      chk("jalr_w_wb_sel", {30'd0, wb_sel}, 32'd2);
      chk("jalr_w_pc_we", {31'd0, pc_we}, 32'd0);
      tick;

      // sub x3,x1,x2
      fetch(32'h402081B3);
      tick;
      chk("sub_e_alu_op", {28'd0, alu_op}, 32'd1);
      tick; tick;
      // addi with imm bit 30 set stays ADD
      fetch(32'h40000093);
      tick;
      chk("addi_e_alu_op", {28'd0, alu_op}, 32'd0);
      chk("addi_e_b_sel", {31'd0, alu_b_sel}, 32'd1);
      tick; tick;
      // srai x1,x1,1
      fetch(32'h4010D093);
      tick;
      chk("srai_e_alu_op", {28'd0, alu_op}, 32'd7);
      tick; tick;
      // lui x5,0x12345
      fetch(32'h123452B7);
      tick;
      chk("lui_e_alu_op", {28'd0, alu_op}, 32'd10);
      chk("lui_e_imm", {29'd0, imm_type}, 32'd4);
      tick; tick;
      // jal x1,+8
      fetch(32'h008000EF);
      tick;
      chk("jal_e_imm", {29'd0, imm_type}, 32'd5);
      chk("jal_e_pc_sel", {30'd0, pc_sel}, 32'd1);
      chk("jal_e_a_sel", {31'd0, alu_a_sel}, 32'd1);
      tick;
      chk("jal_w_wb_sel", {30'd0, wb_sel}, 32'd2);
      tick;

      // illegal opcode
      fetch(32'hFFFFFFFF);
`ifdef ILLEGAL_HALT_EN
      chk("ill_d_state", {29'd0, state}, 32'd1);
      tick;
      chk("ill_halt_state", {29'd0, state}, 32'd5);
      chk("ill_halt_flag", {31'd0, illegal}, 32'd1);
      tick; tick;
      chk("ill_halt_stay", {29'd0, state}, 32'd5);
      chk("ill_halt_sticky", {31'd0, illegal}, 32'd1);
      chk("ill_halt_mem_re", {31'd0, mem_re}, 32'd0);
      rst = 1'b1;
      tick;
      rst = 1'b0; #1;
      chk("ill_rst_state", {29'd0, state}, 32'd0);
      chk("ill_rst_flag", {31'd0, illegal}, 32'd0);
`else
      chk("ill_d_pulse", {31'd0, illegal}, 32'd1);
      chk("ill_d_rf_we", {31'd0, rf_we}, 32'd0);
      chk("ill_d_mem_we", {31'd0, mem_we}, 32'd0);
      chk("ill_d_pc_we", {31'd0, pc_we}, 32'd0);
      tick;
      chk("ill_next_state", {29'd0, state}, 32'd0);
      chk("ill_next_flag", {31'd0, illegal}, 32'd0);
`endif

      // sw x2,8(x1), reset during MEM
      fetch(32'h0020A423);
      chk("sw_d_imm", {29'd0, imm_type}, 32'd2);
      mem_ready = 1'b0;
      tick; tick;
      chk("sw_m_state", {29'd0, state}, 32'd3);
      chk("sw_m_mem_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1; #1;
      chk("sw_rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("sw_rst_rf_we", {31'd0, rf_we}, 32'd0);
      tick;
      chk("sw_rst_state", {29'd0, state}, 32'd0);
      chk("sw_rst_rf_we2", {31'd0, rf_we}, 32'd0);
      rst = 1'b0; #1;
      chk("sw_after_mem_re", {31'd0, mem_re}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I lab CPU.
- Sequences fetch / decode / execute / memory / writeback over a shared ALU and a single memory port.
- Drives the immediate-generator type select (imm_type), ALU operand/op selects, PC, IR, register-file and memory strobes.
- Sits between the instruction register and the datapath muxes; handshakes memory via mem_ready.

Parameters:
- RESET_STATE, 3'd0, encoding of the state entered on reset (FETCH); must stay 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  32  IR contents, stable outside FETCH
- mem_ready  in  1  memory access completes this cycle
- br_taken  in  1  branch comparator result, valid in EXEC
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
- ir_we  out  1  load IR from memory data
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 pc+4, 1 ALU result, 2 ALU result & ~1
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- imm_type  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- alu_a_sel  out  1  0 rs1, 1 old_pc (PC of current instruction)
- alu_b_sel  out  1  0 rs2, 1 imm
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 ALU, 1 mem data, 2 pc+4
- illegal  out  1  unsupported opcode seen

Behaviour:
- Reset: clk-edge with rst=1 → state=FETCH, illegal=0; while rst=1 all strobes (ir_we, pc_we, mem_re, mem_we, rf_we) forced 0. Reset mid-access abandons it; mem_re/mem_we drop the cycle rst rises.
- Outputs are combinational from state and inst. Defaults: all strobes 0, selects 0, alu_op ADD.
- Opcode classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011. Anything else is ILLEGAL.
- imm_type by class, valid in DECODE/EXEC/MEM/WB:
  - I for OPIMM, LOAD, JALR
  - S for STORE
  - B for BRANCH
  - U for LUI, AUIPC
  - J for JAL
  - 0 for OP and ILLEGAL
- FETCH:
  - mem_re=1; hold until mem_ready.
  - On the mem_ready cycle: ir_we=1, pc_we=1, pc_sel=0, then → DECODE.
  - mem_ready=0 stays in FETCH indefinitely.
- DECODE: one cycle → EXEC. ILLEGAL: see optional feature.
- EXEC, one cycle, by class:
  - OP: a=rs1, b=rs2, alu_op from funct3 / funct7[5] (funct3=0 with f7[5]=1 → SUB; funct3=5 with f7[5]=1 → SRA). → WB.
  - OPIMM: b=imm, same map, but funct3=0 is always ADD. → WB.
  - LUI: b=imm, PASSB → WB.
  - AUIPC: a=old_pc, b=imm, ADD → WB.
  - JAL: a=old_pc, b=imm, ADD, pc_we=1, pc_sel=1 → WB.
  - JALR: a=rs1, b=imm, ADD, pc_we=1, pc_sel=2 → WB.
  - BRANCH: a=old_pc, b=imm, ADD, pc_sel=1, pc_we=br_taken → FETCH.
  - LOAD / STORE: a=rs1, b=imm, ADD → MEM.
- MEM:
  - ALU inputs held as in EXEC.
  - LOAD: mem_re=1; STORE: mem_we=1. Held until mem_ready.
  - On mem_ready: LOAD → WB, STORE → FETCH.
- WB:
  - rf_we=1 for exactly one cycle; ALU inputs held as in EXEC.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise. → FETCH.
- HALT: all strobes 0; exited only by rst.
- mem_ready outside FETCH/MEM is ignored.
- Cycle counts from FETCH entry, mem_ready tied 1: OP/OPIMM/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3.

Optional Feature:
- ILLEGAL_HALT_EN defined:
  - ILLEGAL in DECODE sets illegal=1 (sticky until rst) and → HALT.
- ILLEGAL_HALT_EN undefined:
  - ILLEGAL is treated as NOP: DECODE → FETCH with no writes.
  - illegal pulses 1 for that DECODE cycle only.
  - HALT is unreachable.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → states 0,1,2,4,0. EXEC alu_op=0, b_sel=0, imm_type=0. WB rf_we=1, wb_sel=0.
- lw x5,8(x1) (0x0080A283), mem_ready low 3 cycles in MEM → mem_re held 4 cycles. imm_type=1. WB wb_sel=1, rf_we=1. Total 8 cycles.
- beq x0,x0,+16 (0x00000863) with br_taken=1 → EXEC pc_we=1, pc_sel=1, imm_type=3, then FETCH. With br_taken=0 → pc_we=0 in EXEC.
- jalr x1,0(x2) (0x000100E7) → EXEC pc_we=1, pc_sel=2. WB rf_we=1, wb_sel=2.
- inst=0xFFFFFFFF → with ILLEGAL_HALT_EN: state=5, illegal=1 persists. Without: illegal pulses 1 cycle, next state=0, no rf_we/mem_we.
- rst asserted during MEM of sw (0x0020A423) → mem_we=0 the same cycle, state=0 after the edge, no rf_we.
